main_mem_arbiter: RTL and testbench

MAIN_MEM_ARBITER -- requirements
Module: main_mem_arbiter

---
 rtl/main_mem_arbiter_pkg.sv | 11 +
 rtl/main_mem_arbiter_if.sv | 28 ++
 rtl/main_mem_arbiter_rr_arbiter.sv | 25 ++
 rtl/main_mem_arbiter.sv | 107 ++++++++++
 tb/tb_main_mem_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/main_mem_arbiter_pkg.sv
// main_mem_arbiter_pkg: shared FSM encodings and sizing helper for the main-memory arbiter
package main_mem_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_BUSY = 2'b01,
    WR_BUSY = 2'b10
  } state_e;
  function automatic int ptr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/main_mem_arbiter_if.sv
// main_mem_arbiter_if: cache-miss, write-back FIFO and main-memory signals of the arbiter
interface main_mem_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [N_PORTS-1:0]    cm_ReadValid;
  logic [N_PORTS*AW-1:0] cm_ReadAddr;
  logic [N_PORTS-1:0]    cm_ReadReady;
  logic [DW-1:0]         cm_ReadData;
  logic                  FIFO_empty;
  logic [DW+AW-1:0]      FIFO_rd_data;
  logic                  FIFO_re;
  logic                  mem_Valid;
  logic                  mem_RW;
  logic [AW-1:0]         mem_Addr;
  logic [DW-1:0]         mem_WriteData;
  logic                  mem_Ready;
  logic [DW-1:0]         mem_ReadData;
  modport slave (
    input  cm_ReadValid, cm_ReadAddr, FIFO_empty, FIFO_rd_data, mem_Ready, mem_ReadData,
    output cm_ReadReady, cm_ReadData, FIFO_re, mem_Valid, mem_RW, mem_Addr, mem_WriteData
  );
  modport master (
    output cm_ReadValid, cm_ReadAddr, FIFO_empty, FIFO_rd_data, mem_Ready, mem_ReadData,
    input  cm_ReadReady, cm_ReadData, FIFO_re, mem_Valid, mem_RW, mem_Addr, mem_WriteData
  );
endinterface

// File: rtl/main_mem_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant of the first requester found scanning upward from ptr_i with wrap
module rr_arbiter #(
  parameter int N = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  logic found;
  int   idx;
  // scan from the pointer and keep only the first hit
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: shares main memory between per-set miss reads and a write-back FIFO
module main_mem_arbiter
  import main_mem_arbiter_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic CLK,
  input logic Reset_n,
  main_mem_arbiter_if.slave bus
);
  localparam int PW = ptr_w(N_PORTS);
  state_e state_q, state_d;
  logic [N_PORTS-1:0] pend_q, pend_d, rdy_q, rdy_d, arb_gnt;
  logic [AW-1:0] addr_q [N_PORTS];
  logic [AW-1:0] addr_d [N_PORTS];
  logic [PW-1:0] last_q, last_d, gidx_q, gidx_d, ptr, arb_idx;
  logic mem_valid_q, mem_valid_d, mem_rw_q, mem_rw_d, fifo_re_q, fifo_re_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic start_rd, start_wr, rd_done;

  assign ptr = (last_q == PW'(N_PORTS - 1)) ? '0 : last_q + 1'b1;

  rr_arbiter #(.N(N_PORTS), .PW(PW)) u_rr (
    .req_i(pend_q),
    .ptr_i(ptr),
    .gnt_o(arb_gnt)
  );

  // encode the one-hot grant so the winner's address can be selected
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < N_PORTS; i++) if (arb_gnt[i]) arb_idx = PW'(i);
  end

  // state register; reset abandons any in-flight transaction
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // next state plus next values of every registered output and bookkeeping register
  always_comb begin
    state_d = state_q == IDLE ? (!bus.FIFO_empty ? WR_BUSY : (|pend_q ? RD_BUSY : IDLE))
                              : (bus.mem_Ready ? IDLE : state_q);
    start_wr = state_q == IDLE && state_d == WR_BUSY;
    start_rd = state_q == IDLE && state_d == RD_BUSY;
    rd_done = state_q == RD_BUSY && bus.mem_Ready;
    mem_valid_d = start_rd | start_wr;
    mem_rw_d = mem_valid_d ? start_wr : mem_rw_q;
    mem_addr_d = start_wr ? bus.FIFO_rd_data[AW-1:0] : (start_rd ? addr_q[arb_idx] : mem_addr_q);
    mem_wdata_d = start_wr ? bus.FIFO_rd_data[DW+AW-1:AW] : mem_wdata_q;
    fifo_re_d = start_wr;
    gidx_d = start_rd ? arb_idx : gidx_q;
    last_d = rd_done ? gidx_q : last_q;
    rdata_d = rd_done ? bus.mem_ReadData : '0;
    rdy_d = '0;
    pend_d = pend_q;
    addr_d = addr_q;
    for (int i = 0; i < N_PORTS; i++) begin
      rdy_d[i] = rd_done && gidx_q == PW'(i);
      if (rdy_d[i] || !pend_q[i]) begin
        pend_d[i] = bus.cm_ReadValid[i];
        if (bus.cm_ReadValid[i]) addr_d[i] = bus.cm_ReadAddr[i*AW +: AW];
      end
    end
  end

  // datapath and output registers
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_q      <= '0;
      addr_q      <= '{default: '0};
      last_q      <= PW'(N_PORTS - 1);
      gidx_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fifo_re_q   <= 1'b0;
      rdy_q       <= '0;
      rdata_q     <= '0;
    end else begin
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      gidx_q      <= gidx_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fifo_re_q   <= fifo_re_d;
      rdy_q       <= rdy_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.mem_Valid     = mem_valid_q;
  assign bus.mem_RW        = mem_rw_q;
  assign bus.mem_Addr      = mem_addr_q;
  assign bus.mem_WriteData = mem_wdata_q;
  assign bus.FIFO_re       = fifo_re_q;
  assign bus.cm_ReadReady  = rdy_q;
  assign bus.cm_ReadData   = rdata_q;
endmodule

// File: tb/tb_main_mem_arbiter.sv
// tb_main_mem_arbiter: scoreboard bench for the main-memory arbiter
module tb_main_mem_arbiter;
  localparam int N = 4, AW = 32, DW = 32;
  typedef struct packed {logic [3:0] rdy; logic [31:0] data;} rd_t;
  typedef struct packed {logic rw; logic [31:0] addr; logic [31:0] wdata;} mem_t;

  logic CLK = 1'b0;
  logic Reset_n = 1'b0;
  rd_t  exp_rd[$];
  mem_t exp_mem[$];
  rd_t  r;
  mem_t m;
  logic [63:0] fifo_mem [4];
  logic [7:0] fifo_wr = '0;
  logic [7:0] fifo_rd = '0;
  int lat = 3;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] resp_addr;

  main_mem_arbiter_if #(.N_PORTS(N), .AW(AW), .DW(DW)) bus();
  main_mem_arbiter #(.N_PORTS(N), .AW(AW), .DW(DW)) dut (.CLK(CLK), .Reset_n(Reset_n), .bus(bus));

  always #5 CLK = ~CLK;

  assign bus.FIFO_empty   = fifo_rd == fifo_wr;
  assign bus.FIFO_rd_data = fifo_mem[fifo_rd[1:0]];
  always @(posedge CLK) if (bus.FIFO_re) fifo_rd <= fifo_rd + 8'd1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a == 32'h100 ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // memory model: answers every request lat cycles after mem_Valid
  initial begin
    bus.mem_Ready = 1'b0;
    bus.mem_ReadData = '0;
    forever begin
      @(posedge CLK); #1;
      if (bus.mem_Valid) begin
        resp_addr = bus.mem_Addr;
        repeat (lat) begin @(posedge CLK); #1; end
        bus.mem_Ready = 1'b1;
        bus.mem_ReadData = mem_data(resp_addr);
        @(posedge CLK); #1;
        bus.mem_Ready = 1'b0;
        bus.mem_ReadData = '0;
      end
    end
  end

  // monitor: pops expected read completions and memory requests as the DUT presents them
  initial forever begin
    @(negedge CLK);
    if (Reset_n) begin
      if (bus.cm_ReadReady != '0) begin
        if (exp_rd.size() == 0) begin
          n_chk++;
          $display("FAIL rd_unexpected: got ready %b data %h, expected no completion", bus.cm_ReadReady, bus.cm_ReadData);
        end else begin
          r = exp_rd.pop_front();
          check("rd_done", {bus.cm_ReadReady, bus.cm_ReadData}, r);
        end
      end else check("rdata_idle_zero", bus.cm_ReadData, 0);
      if (bus.mem_Valid) begin
        if (exp_mem.size() == 0) begin
          n_chk++;
          $display("FAIL mem_unexpected: got rw %b addr %h, expected no request", bus.mem_RW, bus.mem_Addr);
        end else begin
          m = exp_mem.pop_front();
          check("mem_req", {bus.mem_RW, bus.mem_Addr, bus.mem_RW ? bus.mem_WriteData : 32'h0},
                {m.rw, m.addr, m.rw ? m.wdata : 32'h0});
        end
      end
    end
  end

  task automatic req(input logic [3:0] msk, input logic [127:0] a);
    @(posedge CLK); #1;
    bus.cm_ReadValid = msk;
    bus.cm_ReadAddr = a;
    @(posedge CLK); #1;
    bus.cm_ReadValid = '0;
    bus.cm_ReadAddr = '0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((exp_rd.size() != 0 || exp_mem.size() != 0) && k < 300) begin
      @(posedge CLK); #1;
      k++;
    end
    if (k >= 300) begin
      n_chk++;
      $display("FAIL %s: got %0d reads and %0d requests outstanding, expected 0", name, exp_rd.size(), exp_mem.size());
    end
    repeat (4) @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.cm_ReadValid = '0;
    bus.cm_ReadAddr = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_outputs", {bus.mem_Valid, bus.mem_RW, bus.mem_Addr, bus.mem_WriteData, bus.FIFO_re,
                            bus.cm_ReadReady, bus.cm_ReadData}, 0);
    Reset_n = 1'b1;
    repeat (2) @(posedge CLK);
    // single read on port 2, two-cycle request latency
    exp_mem.push_back('{1'b0, 32'h100, 32'h0});
    exp_rd.push_back('{4'b0100, 32'hDEADBEEF});
    req(4'b0100, {32'h0, 32'h100, 64'h0});
    check("latency_not_yet", bus.mem_Valid, 0);
    @(posedge CLK); #1;
    check("latency_two", {bus.mem_Valid, bus.mem_Addr}, {1'b1, 32'h100});
    wait_idle("single_read");
    // reset while a read to port 3 is outstanding; its late mem_Ready must be ignored
    lat = 6;
    exp_mem.push_back('{1'b0, 32'h300, 32'h0});
    req(4'b1000, {32'h300, 96'h0});
    @(posedge CLK); #1;
    check("pre_reset_req", {bus.mem_Valid, bus.mem_Addr}, {1'b1, 32'h300});
    @(posedge CLK); #1;
    check("pre_reset_addr_held", {bus.mem_Valid, bus.mem_Addr}, {1'b0, 32'h300});
    Reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {bus.mem_Valid, bus.mem_RW, bus.mem_Addr, bus.mem_WriteData, bus.FIFO_re,
                                  bus.cm_ReadReady, bus.cm_ReadData}, 0);
    repeat (2) begin @(posedge CLK); #1; end
    Reset_n = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    check("late_ready_ignored", {bus.mem_Valid, bus.cm_ReadReady}, 0);
    lat = 3;
    // two batches of simultaneous requests, each served 0,1,2,3
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < 4; p++) begin
        exp_mem.push_back('{1'b0, 32'h10 + 32'(b * 16 + p * 4), 32'h0});
        exp_rd.push_back('{4'b0001 << p, 32'hC0DE_0010 + 32'(b * 16 + p * 4)});
      end
      req(4'b1111, b == 0 ? {32'h1C, 32'h18, 32'h14, 32'h10} : {32'h2C, 32'h28, 32'h24, 32'h20});
      wait_idle("batch");
    end
    // write-back has priority over a pending read
    exp_mem.push_back('{1'b1, 32'h200, 32'h12345678});
    exp_mem.push_back('{1'b0, 32'h40, 32'h0});
    exp_rd.push_back('{4'b0010, 32'hC0DE_0040});
    fifo_mem[fifo_wr[1:0]] = {32'h12345678, 32'h200};
    fifo_wr = fifo_wr + 8'd1;
    req(4'b0010, {64'h0, 32'h40, 32'h0});
    wait_idle("write_first");
    check("fifo_pops", {fifo_rd, bus.FIFO_empty}, {8'd1, 1'b1});
    // port 0 re-requests in the cycle its mem_Ready arrives
    exp_mem.push_back('{1'b0, 32'h80, 32'h0});
    exp_mem.push_back('{1'b0, 32'h84, 32'h0});
    exp_rd.push_back('{4'b0001, 32'hC0DE_0080});
    exp_rd.push_back('{4'b0001, 32'hC0DE_0084});
    req(4'b0001, {96'h0, 32'h80});
    @(posedge CLK); #1;
    check("rereq_first_valid", {bus.mem_Valid, bus.mem_Addr}, {1'b1, 32'h80});
    repeat (3) begin @(posedge CLK); #1; end
    bus.cm_ReadValid = 4'b0001;
    bus.cm_ReadAddr = {96'h0, 32'h84};
    @(posedge CLK); #1;
    bus.cm_ReadValid = '0;
    bus.cm_ReadAddr = '0;
    wait_idle("rereq");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected end of run");
    $fatal(1);
  end
endmodule
